mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
// - MEM-stage load/store unit between the EX/MEM pipeline register and the word-addressed DataMemory.
// - Translates byte addresses to word indices and drives DataMemory's read_write/address/data.
// - Performs LB/LBU/LH/LHU/LW with sign/zero extension; SB/SH via read-modify-write; SW direct.
// - Produces a registered result pulse for the MEM/WB register; stalls EX/MEM via in_ready.
// PARAMETERS
// - MEM_DEPTH  32  number of 32-bit words in DataMemory; word index >= MEM_DEPTH is a fault
// PORTS
// - clk            in   1   clock, all state on posedge
// - rst            in   1   reset: asynchronous, active-low
// - in_valid       in   1   EX/MEM holds a valid instruction
// - in_ready       out  1   unit accepts in_* this cycle (high only in IDLE)
// - in_mem_read    in   1   load
// - in_mem_write   in   1   store
// - in_size        in   2   00 byte, 01 half, 10 word, 11 illegal
// - in_unsigned    in   1   zero-extend loads (LBU/LHU)
// - in_addr        in   32  byte address / ALU result
// - in_wdata       in   32  store data (low byte/half used for SB/SH)
// - in_rd          in   5   destination register
// - in_reg_write   in   1   writeback enable
// - mem_rw         out  2   to DataMemory read_write: 00 idle, 01 write, 10 read
// - mem_addr       out  32  word index = {2'b00, addr[31:2]}
// - mem_wdata      out  32  word to write
// - mem_rdata      in   32  DataMemory outData; valid at posedge following a read cycle
// - out_valid      out  1   one-cycle pulse, result for MEM/WB
// - out_data       out  32  load result or ALU pass-through
// - out_rd         out  5   registered in_rd
// - out_reg_write  out  1   writeback enable (0 on stores and faults)
// - out_fault      out  1   misaligned, illegal size, read&write both set, or out of range
// BEHAVIOUR
// - Little-endian: byte lane = addr[1:0], lane 0 = bits 7:0; halfword lane = addr[1].
// - States: IDLE, LOAD, STORE, RMW_RD, RMW_WR. in_ready = (state == IDLE).
// - Accept = in_valid & in_ready. Operands latched into internal registers on accept.
// - Fault check at accept: half with addr[0]=1; word with addr[1:0]!=0; size 11; read&write both set;
//   addr[31:2] >= MEM_DEPTH. Fault -> no memory cycle, out_valid next posedge, out_fault=1,
//   out_reg_write=0, out_data=0, stay IDLE.
// - No mem op: out_valid next posedge, out_data=in_addr, out_reg_write=in_reg_write (latency 1).
// - Load: IDLE->LOAD; mem_rw=10 during LOAD; at end of LOAD sample mem_rdata, extract lane,
//   extend, pulse out_valid, ->IDLE. Accept-to-out_valid latency 2.
// - SW: IDLE->STORE; mem_rw=01, mem_wdata=in_wdata; ->IDLE with out_valid, out_reg_write=0. Latency 2.
// - SB/SH: IDLE->RMW_RD (mem_rw=10) ->RMW_WR (mem_rw=01, mem_wdata = sampled word with addressed
//   lane replaced) ->IDLE with out_valid, out_reg_write=0. Latency 3.
// - mem_rw, mem_addr, mem_wdata are decoded from the registered state only; mem_rw=00 in IDLE.
// - New accept is allowed in the same cycle out_valid is high (back-to-back, no bubble).
// - Outputs registered; out_valid is high for exactly one cycle per accepted instruction.
// - Reset (rst=0): state IDLE, mem_rw=00, mem_addr=0, mem_wdata=0, out_valid=0, out_data=0,
//   out_rd=0, out_reg_write=0, out_fault=0; in_ready=1.
// - Reset mid-operation: abort immediately, no memory write issued after rst falls, no out_valid.
// TESTING
// - SW 0xDEADBEEF @0x08, then LW @0x08 -> mem_rw=01 mem_addr=2 mem_wdata=0xDEADBEEF;
//   out_data=0xDEADBEEF 2 cycles after accept.
// - SB 0x5A @0x09 over 0xDEADBEEF -> RMW writes 0xDEAD5AEF; LBU @0x09 -> 0x0000005A;
//   LB @0x08 -> 0xFFFFFFEF.
// - SH 0x8234 @0x0A -> word 0x82345AEF; LH @0x0A -> 0xFFFF8234; LHU @0x0A -> 0x00008234.
// - LW @0x06, LH @0x03, LW @0x80 (MEM_DEPTH=32) -> out_fault=1, out_reg_write=0, mem_rw stays 00.
// - ALU op addr=0x1234, rd=7, reg_write=1, followed next cycle by LW -> out_data=0x1234 out_rd=7 at
//   latency 1, LW accepted with no bubble.
// - rst=0 during RMW_RD of an SB -> all outputs 0 asynchronously, no write to DataMemory,
//   in_ready=1 after release, memory word unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : MEM-stage load/store unit: byte-addressed loads/stores onto a
//           word-addressed DataMemory, with RMW for sub-word stores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int MEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic [1:0]  mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_fault
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4
    } state_t;

    localparam logic [1:0]  c_rw_idle   = 2'b00;
    localparam logic [1:0]  c_rw_write  = 2'b01;
    localparam logic [1:0]  c_rw_read   = 2'b10;
    localparam logic [1:0]  c_size_byte = 2'b00;
    localparam logic [1:0]  c_size_half = 2'b01;
    localparam logic [1:0]  c_size_word = 2'b10;
    localparam logic [31:0] c_mem_depth = 32'(MEM_DEPTH);

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [4:0]  r_rd;
    logic        r_reg_write;

    logic        w_accept;
    logic        w_mem_op;
    logic        w_fault;
    logic [31:0] w_word_addr;

    assign in_ready    = (r_state == S_IDLE);
    assign w_accept    = in_valid & in_ready;
    assign w_mem_op    = in_mem_read | in_mem_write;
    assign w_word_addr = {2'b00, r_addr[31:2]};

    // Faults only apply to memory ops; ALU results pass through untouched.
    assign w_fault = w_mem_op & ((in_size == 2'b11) |
                                 ((in_size == c_size_half) & in_addr[0]) |
                                 ((in_size == c_size_word) & (in_addr[1:0] != 2'b00)) |
                                 (in_mem_read & in_mem_write) |
                                 ({2'b00, in_addr[31:2]} >= c_mem_depth));

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            c_size_byte: res = uns ? {24'b0, b} : {{24{b[7]}}, b};
            c_size_half: res = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default:     res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [31:0] wdata,
                                            input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] res;
        res = word;
        if (size == c_size_byte) begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = wdata[15:0];
        end else begin
            res[15:0] = wdata[15:0];
        end
        return res;
    endfunction

    always_comb begin
        mem_rw    = c_rw_idle;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        case (r_state)
            S_LOAD, S_RMW_RD: begin
                mem_rw   = c_rw_read;
                mem_addr = w_word_addr;
            end
            S_STORE: begin
                mem_rw    = c_rw_write;
                mem_addr  = w_word_addr;
                mem_wdata = r_wdata;
            end
            S_RMW_WR: begin
                mem_rw    = c_rw_write;
                mem_addr  = w_word_addr;
                mem_wdata = r_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_addr        <= 32'b0;
            r_wdata       <= 32'b0;
            r_word        <= 32'b0;
            r_size        <= 2'b00;
            r_unsigned    <= 1'b0;
            r_rd          <= 5'b0;
            r_reg_write   <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 32'b0;
            out_rd        <= 5'b0;
            out_reg_write <= 1'b0;
            out_fault     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= in_addr;
                        r_wdata     <= in_wdata;
                        r_size      <= in_size;
                        r_unsigned  <= in_unsigned;
                        r_rd        <= in_rd;
                        r_reg_write <= in_reg_write;
                        if (w_fault) begin
                            out_valid     <= 1'b1;
                            out_data      <= 32'b0;
                            out_rd        <= in_rd;
                            out_reg_write <= 1'b0;
                            out_fault     <= 1'b1;
                        end else if (in_mem_read) begin
                            r_state <= S_LOAD;
                        end else if (in_mem_write) begin
                            r_state <= (in_size == c_size_word) ? S_STORE : S_RMW_RD;
                        end else begin
                            out_valid     <= 1'b1;
                            out_data      <= in_addr;
                            out_rd        <= in_rd;
                            out_reg_write <= in_reg_write;
                            out_fault     <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    r_state       <= S_IDLE;
                    out_valid     <= 1'b1;
                    out_data      <= f_extract(mem_rdata, r_addr[1:0], r_size, r_unsigned);
                    out_rd        <= r_rd;
                    out_reg_write <= r_reg_write;
                    out_fault     <= 1'b0;
                end
                S_RMW_RD: begin
                    r_state <= S_RMW_WR;
                    r_word  <= f_merge(mem_rdata, r_wdata, r_addr[1:0], r_size);
                end
                S_STORE, S_RMW_WR: begin
                    r_state       <= S_IDLE;
                    out_valid     <= 1'b1;
                    out_data      <= r_addr;
                    out_rd        <= r_rd;
                    out_reg_write <= 1'b0;
                    out_fault     <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
